// File: rtl/rtc_bus_scheduler_pkg.sv
// Shared RTC definitions: register map, shadow slot numbering and scheduler state encoding.
package rtc_pkg;

  localparam int NREG_DEF    = 9;
  localparam int TIMEOUT_DEF = 255;

  typedef logic [3:0] slot_t;

  // Shadow memory slots hold the time/alarm registers in burst order.
  localparam slot_t SLOT_FIRST = 4'd1;
  localparam slot_t SLOT_LAST  = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_USR_ST,
    ST_USR_WT,
    ST_RD_ST,
    ST_RD_WT,
    ST_RD_STO
  } state_t;

  // sec, min, hour, day, month, year, alarm sec/min/hour
  function automatic logic [7:0] rtc_addr(input slot_t idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd6:    a = 8'h41;
      4'd7:    a = 8'h42;
      4'd8:    a = 8'h43;
      default: a = 8'h21;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_bus_scheduler_if.sv
// Handshake between the scheduler (sole bus master) and the RTC bus driver.
interface rtc_bus_scheduler_if;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       done;
  logic [7:0] rdata;

  modport master (output start, rw, addr, wdata, input done, rdata);
  modport slave  (input start, rw, addr, wdata, output done, rdata);
endinterface

// File: rtl/rtc_bus_watchdog.sv
// Transaction watchdog: counts while enabled, flags when the count reaches TIMEOUT.
module rtc_bus_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int W       = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                     r_cnt <= '0;
    else if (i_clear)              r_cnt <= '0;
    else if (i_en && !o_expired)   r_cnt <= r_cnt + W'(1);
  end

  assign o_expired = (r_cnt == W'(TIMEOUT));

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates the RTC bus driver between 1 Hz shadow refresh bursts and user register writes.
module rtc_bus_scheduler
  import rtc_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_tick,
  input  logic                       i_usr_req,
  input  logic [7:0]                 i_usr_addr,
  input  logic [7:0]                 i_usr_data,
  output logic                       o_usr_done,
  rtc_bus_scheduler_if.master        bus,
  output logic                       o_mem_we,
  output logic [3:0]                 o_mem_addr,
  output logic [7:0]                 o_mem_data,
  output logic                       o_busy,
  output logic                       o_refresh_done,
  output logic                       o_overrun,
  output logic                       o_timeout_err
);

  localparam slot_t LAST_IDX = slot_t'(NREG - 1);

  state_t     r_state;
  slot_t      r_idx;
  logic       r_tick_pend, r_overrun, r_timeout_err;
  logic       r_start, r_rw, r_usr_done, r_mem_we, r_busy, r_refresh_done;
  logic [7:0] r_addr, r_wdata, r_mem_data;
  slot_t      r_mem_addr;
  logic       w_usr_go, w_rd_launch, w_wd_clear, w_wd_en, w_wd_expired;

  // A request still held during its own usr_done cycle must not start a second write.
  assign w_usr_go    = i_usr_req && !r_usr_done;
  assign w_rd_launch = (r_state == ST_IDLE) && !w_usr_go && r_tick_pend;
  assign w_wd_clear  = (r_state == ST_USR_ST) || (r_state == ST_RD_ST);
  assign w_wd_en     = (r_state == ST_USR_WT) || (r_state == ST_RD_WT);

  rtc_bus_watchdog #(.TIMEOUT(TIMEOUT), .W(8)) u_wdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_wd_clear),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  // A tick coinciding with the launch that consumes the pending one is not an overrun.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tick_pend <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (i_tick) begin
      r_tick_pend <= 1'b1;
      if (r_tick_pend && !w_rd_launch) r_overrun <= 1'b1;
    end else if (w_rd_launch) begin
      r_tick_pend <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_start        <= 1'b0;
      r_rw           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_usr_done     <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_data     <= '0;
      r_busy         <= 1'b0;
      r_refresh_done <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_start        <= 1'b0;
      r_usr_done     <= 1'b0;
      r_mem_we       <= 1'b0;
      r_refresh_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_usr_go) begin
            r_state <= ST_USR_ST;
            r_start <= 1'b1;
            r_rw    <= 1'b0;
            r_addr  <= i_usr_addr;
            r_wdata <= i_usr_data;
            r_busy  <= 1'b1;
          end else if (r_tick_pend) begin
            r_state <= ST_RD_ST;
            r_idx   <= '0;
            r_start <= 1'b1;
            r_rw    <= 1'b1;
            r_addr  <= rtc_addr(4'd0);
            r_busy  <= 1'b1;
          end
        end
        ST_USR_ST: r_state <= ST_USR_WT;
        ST_USR_WT: begin
          if (bus.done || w_wd_expired) begin
            if (!bus.done) r_timeout_err <= 1'b1;
            r_usr_done <= 1'b1;
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
          end
        end
        ST_RD_ST: r_state <= ST_RD_WT;
        ST_RD_WT: begin
          if (bus.done) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_idx + SLOT_FIRST;
            r_mem_data <= bus.rdata;
            r_state    <= ST_RD_STO;
          end else if (w_wd_expired) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
          end
        end
        ST_RD_STO: begin
          if (r_idx == LAST_IDX) begin
            r_refresh_done <= 1'b1;
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_start <= 1'b1;
            r_rw    <= 1'b1;
            r_addr  <= rtc_addr(r_idx + 4'd1);
            r_state <= ST_RD_ST;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start      = r_start;
  assign bus.rw         = r_rw;
  assign bus.addr       = r_addr;
  assign bus.wdata      = r_wdata;
  assign o_usr_done     = r_usr_done;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_data     = r_mem_data;
  assign o_busy         = r_busy;
  assign o_refresh_done = r_refresh_done;
  assign o_overrun      = r_overrun;
  assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler with a bus-driver model and event logging.
module tb_rtc_bus_scheduler;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         cyc;
  } start_ev_t;

  typedef struct {
    logic [3:0] slot;
    logic [7:0] data;
  } mem_ev_t;

  logic       clk, rst, tick, usr_req;
  logic [7:0] usr_addr, usr_data;
  logic       usr_done, mem_we, busy, refresh_done, overrun, timeout_err;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;

  rtc_bus_scheduler_if bus ();

  rtc_bus_scheduler dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_tick         (tick),
    .i_usr_req      (usr_req),
    .i_usr_addr     (usr_addr),
    .i_usr_data     (usr_data),
    .o_usr_done     (usr_done),
    .bus            (bus),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_data     (mem_data),
    .o_busy         (busy),
    .o_refresh_done (refresh_done),
    .o_overrun      (overrun),
    .o_timeout_err  (timeout_err)
  );

  logic [7:0] exp_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  start_ev_t start_q[$];
  mem_ev_t   mem_q[$];
  int n_refresh = 0, refresh_cyc = 0, n_usr = 0, usr_cyc = 0;
  int te_cyc = 0;
  bit te_seen = 0;
  bit drv_skip = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Event log, sampled just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    if (bus.start)    start_q.push_back('{bus.rw, bus.addr, bus.wdata, cyc});
    if (mem_we)       mem_q.push_back('{mem_addr, mem_data});
    if (refresh_done) begin n_refresh = n_refresh + 1; refresh_cyc = cyc; end
    if (usr_done)     begin n_usr = n_usr + 1; usr_cyc = cyc; end
    if (timeout_err && !te_seen) begin te_seen = 1; te_cyc = cyc; end
  end

  // Driver model: done two cycles after start, rdata = addr ^ A5; optionally ignores reads of 8'h23
  initial begin
    logic [7:0] a;
    bus.done  = 1'b0;
    bus.rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.start) begin
        a = bus.addr;
        if (!(drv_skip && a == 8'h23)) begin
          repeat (2) @(negedge clk);
          bus.done  = 1'b1;
          bus.rdata = a ^ 8'hA5;
          @(negedge clk);
          bus.done  = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    start_q.delete();
    mem_q.delete();
    n_refresh = 0;
    n_usr = 0;
  endtask

  task automatic pulse_tick(output int t_cyc);
    @(negedge clk);
    tick  = 1'b1;
    t_cyc = cyc;
    @(negedge clk);
    tick  = 1'b0;
  endtask

  task automatic wait_starts(input string tag, input int n, input int bound);
    int k = 0;
    while (start_q.size() < n && k < bound) begin @(negedge clk); k++; end
    check(tag, 32'(start_q.size() >= n), 32'd1);
  endtask

  task automatic wait_refresh(input string tag, input int n, input int bound);
    int k = 0;
    while (n_refresh < n && k < bound) begin @(negedge clk); k++; end
    check(tag, 32'(n_refresh >= n), 32'd1);
  endtask

  task automatic wait_usr_done(input string tag, input int bound);
    int k = 0;
    while (!usr_done && k < bound) begin @(negedge clk); k++; end
    check(tag, 32'(usr_done), 32'd1);
    usr_req = 1'b0;
  endtask

  task automatic check_burst(input string tag, input int off);
    for (int i = 0; i < 9; i++) begin
      if (off + i < start_q.size()) begin
        check({tag, "_rw"},   32'(start_q[off+i].rw), 32'd1);
        check({tag, "_addr"}, 32'(start_q[off+i].addr), 32'(exp_addr[i]));
      end
    end
  endtask

  initial begin
    int t_cyc, k, wstart;
    rst = 1'b1; tick = 1'b0; usr_req = 1'b0; usr_addr = 8'h00; usr_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_start", 32'(bus.start), 32'd0);
    check("rst_addr",  32'(bus.addr), 32'd0);
    check("rst_memwe", 32'(mem_we), 32'd0);
    check("rst_flags", {28'd0, usr_done, refresh_done, overrun, timeout_err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single refresh burst
    clear_logs();
    pulse_tick(t_cyc);
    wait_refresh("t1_wait", 1, 200);
    repeat (5) @(negedge clk);
    check("t1_nstart", start_q.size(), 9);
    check("t1_lat", start_q[0].cyc - t_cyc, 2);
    check("t1_span", start_q[8].cyc - start_q[0].cyc, 32);
    check_burst("t1", 0);
    check("t1_nmem", mem_q.size(), 9);
    for (int i = 0; i < 9 && i < mem_q.size(); i++) begin
      check("t1_slot", 32'(mem_q[i].slot), 32'(i + 1));
      check("t1_data", 32'(mem_q[i].data), 32'(exp_addr[i] ^ 8'hA5));
    end
    check("t1_nref", n_refresh, 1);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: user request and tick in the same cycle
    clear_logs();
    @(negedge clk);
    usr_req = 1'b1; usr_addr = 8'h22; usr_data = 8'h30; tick = 1'b1; t_cyc = cyc;
    @(negedge clk);
    tick = 1'b0;
    wait_usr_done("t2_udone", 20);
    wait_refresh("t2_wait", 1, 200);
    repeat (5) @(negedge clk);
    check("t2_nstart", start_q.size(), 10);
    check("t2_w_rw", 32'(start_q[0].rw), 32'd0);
    check("t2_w_addr", 32'(start_q[0].addr), 32'h22);
    check("t2_w_data", 32'(start_q[0].wdata), 32'h30);
    check("t2_w_lat", start_q[0].cyc - t_cyc, 1);
    check("t2_order", 32'(usr_cyc < start_q[1].cyc), 32'd1);
    check_burst("t2", 1);
    check("t2_nusr", n_usr, 1);
    check("t2_nref", n_refresh, 1);

    // 3: user request arrives at read 4 of a burst
    clear_logs();
    pulse_tick(t_cyc);
    wait_starts("t3_w4", 4, 100);
    usr_req = 1'b1; usr_addr = 8'h24; usr_data = 8'h12;
    wait_usr_done("t3_udone", 200);
    repeat (5) @(negedge clk);
    check("t3_nstart", start_q.size(), 10);
    check_burst("t3", 0);
    check("t3_w_rw", 32'(start_q[9].rw), 32'd0);
    check("t3_w_addr", 32'(start_q[9].addr), 32'h24);
    check("t3_w_data", 32'(start_q[9].wdata), 32'h12);
    check("t3_nref", n_refresh, 1);
    check("t3_w_after", start_q[9].cyc - refresh_cyc, 1);
    check("t3_order", 32'(refresh_cyc < usr_cyc), 32'd1);
    check("t3_ovr", 32'(overrun), 32'd0);

    // 4: two more ticks during a burst
    clear_logs();
    pulse_tick(t_cyc);
    wait_starts("t4_w2", 2, 100);
    pulse_tick(t_cyc);
    wait_starts("t4_w4", 4, 100);
    pulse_tick(t_cyc);
    wait_refresh("t4_wait", 2, 400);
    repeat (60) @(negedge clk);
    check("t4_ovr", 32'(overrun), 32'd1);
    check("t4_nref", n_refresh, 2);
    check("t4_nstart", start_q.size(), 18);
    check_burst("t4b", 9);

    // 5: driver never answers the read of 8'h23
    clear_logs();
    drv_skip = 1;
    check("t5_te0", 32'(timeout_err), 32'd0);
    pulse_tick(t_cyc);
    k = 0;
    while (!te_seen && k < 400) begin @(negedge clk); k++; end
    check("t5_te", 32'(timeout_err), 32'd1);
    repeat (5) @(negedge clk);
    check("t5_nstart", start_q.size(), 3);
    if (start_q.size() >= 3) check("t5_tlat", te_cyc - start_q[2].cyc, 257);
    check("t5_nmem", mem_q.size(), 2);
    check("t5_nref", n_refresh, 0);
    check("t5_busy", 32'(busy), 32'd0);
    drv_skip = 0;
    clear_logs();
    pulse_tick(t_cyc);
    wait_refresh("t5_rewait", 1, 200);
    check("t5_restart", 32'(start_q[0].addr), 32'h21);
    check("t5_renmem", mem_q.size(), 9);

    // 6: reset while waiting on the first read
    repeat (5) @(negedge clk);
    clear_logs();
    pulse_tick(t_cyc);
    wait_starts("t6_w1", 1, 20);
    wstart = start_q[0].cyc;
    while (cyc < wstart + 1) @(negedge clk);
    check("t6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_addr", 32'(bus.addr), 32'd0);
    check("t6_flags", {28'd0, usr_done, refresh_done, overrun, timeout_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_nmem", mem_q.size(), 0);
    check("t6_nstart", start_q.size(), 1);
    check("t6_busy_post", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
